lieat_exu_oitf: RTL and testbench

//  Outstanding Instruction Track FIFO between dispatch and lieat_exu. One entry is allocated per

---
 rtl/lieat_exu_oitf.sv | 99 +++++++++
 tb/tb_lieat_exu_oitf.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lieat_exu_oitf.sv
// Outstanding Instruction Track FIFO: tracks in-flight long-pipe instructions
// and flags RAW/WAW hazards for the dispatch candidate.
module lieat_exu_oitf #(
    parameter int unsigned OITF_DEPTH = 4,
    parameter int unsigned RIDX_W     = 5,
    localparam int unsigned PTR_W     = $clog2(OITF_DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              dis_ena,
    input  logic              dis_rdwen,
    input  logic [RIDX_W-1:0] dis_rd,
    output logic [PTR_W-1:0]  dis_ptr,
    input  logic              dis_rs1en,
    input  logic              dis_rs2en,
    input  logic [RIDX_W-1:0] dis_rs1,
    input  logic [RIDX_W-1:0] dis_rs2,
    output logic              oitf_raw_dep,
    output logic              oitf_waw_dep,
    output logic              oitf_full,
    output logic              oitf_empty,
    input  logic              ret_ena,
    output logic [PTR_W-1:0]  ret_ptr,
    output logic              ret_rdwen,
    output logic [RIDX_W-1:0] ret_rd
);

    logic [OITF_DEPTH-1:0] vld;
    logic [OITF_DEPTH-1:0] rdwen;
    logic [RIDX_W-1:0]     rd [OITF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  wr_flg;
    logic                  rd_flg;
    logic                  alloc;
    logic                  retire;

    // Pointer advance with wrap; the flag toggles on every wrap so full/empty stay distinct.
    function automatic logic [PTR_W:0] ptr_inc(input logic flg, input logic [PTR_W-1:0] p);
        if (p == PTR_W'(OITF_DEPTH - 1)) begin
            return {~flg, PTR_W'(0)};
        end
        return {flg, p + PTR_W'(1)};
    endfunction

    assign oitf_empty = (wr_ptr == rd_ptr) && (wr_flg == rd_flg);
    assign oitf_full  = (wr_ptr == rd_ptr) && (wr_flg != rd_flg);
    assign alloc      = dis_ena && !oitf_full;
    assign retire     = ret_ena && !oitf_empty;

    assign dis_ptr   = wr_ptr;
    assign ret_ptr   = rd_ptr;
    assign ret_rdwen = !oitf_empty && rdwen[rd_ptr];
    assign ret_rd    = oitf_empty ? '0 : rd[rd_ptr];

    // Flush returns the tracker to exactly its reset state.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            vld    <= '0;
            rdwen  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            wr_flg <= 1'b0;
            rd_flg <= 1'b0;
            for (int i = 0; i < int'(OITF_DEPTH); i++) begin
                rd[i] <= '0;
            end
        end else begin
            if (alloc) begin
                vld[wr_ptr]      <= 1'b1;
                rdwen[wr_ptr]    <= dis_rdwen && (dis_rd != '0);
                rd[wr_ptr]       <= dis_rd;
                {wr_flg, wr_ptr} <= ptr_inc(wr_flg, wr_ptr);
            end
            if (retire) begin
                vld[rd_ptr]      <= 1'b0;
                {rd_flg, rd_ptr} <= ptr_inc(rd_flg, rd_ptr);
            end
        end
    end

    // Hazard match against every outstanding writer, including one retiring this cycle.
    always_comb begin
        oitf_raw_dep = 1'b0;
        oitf_waw_dep = 1'b0;
        for (int i = 0; i < int'(OITF_DEPTH); i++) begin
            if (vld[i] && rdwen[i]) begin
                if ((dis_rs1en && (rd[i] == dis_rs1)) || (dis_rs2en && (rd[i] == dis_rs2))) begin
                    oitf_raw_dep = 1'b1;
                end
                if (dis_rdwen && (rd[i] == dis_rd)) begin
                    oitf_waw_dep = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lieat_exu_oitf.sv
// Bench for lieat_exu_oitf: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_lieat_exu_oitf;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned RW    = 5;
    localparam int unsigned PW    = 2;

    logic          clock = 1'b0;
    logic          reset, flush, dis_ena, dis_rdwen, dis_rs1en, dis_rs2en, ret_ena;
    logic [RW-1:0] dis_rd, dis_rs1, dis_rs2;
    logic [PW-1:0] dis_ptr, ret_ptr;
    logic          oitf_raw_dep, oitf_waw_dep, oitf_full, oitf_empty, ret_rdwen;
    logic [RW-1:0] ret_rd;

    lieat_exu_oitf #(.OITF_DEPTH(DEPTH), .RIDX_W(RW)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .dis_ena(dis_ena), .dis_rdwen(dis_rdwen), .dis_rd(dis_rd), .dis_ptr(dis_ptr),
        .dis_rs1en(dis_rs1en), .dis_rs2en(dis_rs2en), .dis_rs1(dis_rs1), .dis_rs2(dis_rs2),
        .oitf_raw_dep(oitf_raw_dep), .oitf_waw_dep(oitf_waw_dep),
        .oitf_full(oitf_full), .oitf_empty(oitf_empty),
        .ret_ena(ret_ena), .ret_ptr(ret_ptr), .ret_rdwen(ret_rdwen), .ret_rd(ret_rd)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          rdwen;
        logic [RW-1:0] rd;
    } ent_t;

    ent_t q[$];
    int   m_wp = 0;
    int   m_rp = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs derived from the in-order queue of outstanding writers.
    task automatic model_check();
        logic raw, waw;
        raw = 1'b0;
        waw = 1'b0;
        foreach (q[i]) begin
            if (q[i].rdwen) begin
                if ((dis_rs1en && q[i].rd == dis_rs1) || (dis_rs2en && q[i].rd == dis_rs2)) raw = 1'b1;
                if (dis_rdwen && q[i].rd == dis_rd) waw = 1'b1;
            end
        end
        chk("full",      32'(oitf_full),    32'(q.size() == DEPTH));
        chk("empty",     32'(oitf_empty),   32'(q.size() == 0));
        chk("dis_ptr",   32'(dis_ptr),      32'(m_wp));
        chk("ret_ptr",   32'(ret_ptr),      32'(m_rp));
        chk("ret_rdwen", 32'(ret_rdwen),    q.size() > 0 ? 32'(q[0].rdwen) : 32'd0);
        chk("ret_rd",    32'(ret_rd),       q.size() > 0 ? 32'(q[0].rd) : 32'd0);
        chk("raw",       32'(oitf_raw_dep), 32'(raw));
        chk("waw",       32'(oitf_waw_dep), 32'(waw));
    endtask

    task automatic model_update();
        bit do_ret, do_alloc;
        if (reset || flush) begin
            q.delete();
            m_wp = 0;
            m_rp = 0;
        end else begin
            do_ret   = ret_ena && q.size() > 0;
            do_alloc = dis_ena && q.size() < DEPTH;
            if (do_ret) begin
                void'(q.pop_front());
                m_rp = (m_rp + 1) % DEPTH;
            end
            if (do_alloc) begin
                q.push_back('{rdwen: dis_rdwen && dis_rd != 0, rd: dis_rd});
                m_wp = (m_wp + 1) % DEPTH;
            end
        end
    endtask

    task automatic sample();
        @(negedge clock);
        model_check();
    endtask

    task automatic advance();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    task automatic idle();
        reset = 0; flush = 0; dis_ena = 0; ret_ena = 0; dis_rdwen = 0;
        dis_rs1en = 0; dis_rs2en = 0; dis_rd = '0; dis_rs1 = '0; dis_rs2 = '0;
    endtask

    task automatic alloc(input logic [RW-1:0] r);
        idle();
        dis_ena = 1; dis_rdwen = 1; dis_rd = r;
        cyc();
    endtask

    task automatic do_flush();
        idle();
        flush = 1;
        cyc();
        idle();
    endtask

    int exp_rp[6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        idle();
        reset = 1;
        @(posedge clock);
        #1;
        sample();
        chk("rst_empty", 32'(oitf_empty), 32'd1);
        chk("rst_full", 32'(oitf_full), 32'd0);
        chk("rst_ptrs", {dis_ptr, ret_ptr}, 32'd0);
        advance();

        // 1: single allocation and RAW on rs1 only
        idle();
        dis_ena = 1; dis_rdwen = 1; dis_rd = 5'd5;
        sample();
        chk("t1_dis_ptr", 32'(dis_ptr), 32'd0);
        advance();
        idle();
        dis_rs1en = 1; dis_rs1 = 5'd5;
        sample();
        chk("t1_empty", 32'(oitf_empty), 32'd0);
        chk("t1_raw1", 32'(oitf_raw_dep), 32'd1);
        advance();
        idle();
        dis_rs2en = 1; dis_rs2 = 5'd6;
        sample();
        chk("t1_raw0", 32'(oitf_raw_dep), 32'd0);
        advance();

        // 2: fill, overflow attempt, retire
        do_flush();
        for (int i = 1; i <= 4; i++) alloc(RW'(i));
        idle();
        dis_ena = 1; dis_rdwen = 1; dis_rd = 5'd9;
        sample();
        chk("t2_full", 32'(oitf_full), 32'd1);
        chk("t2_wrap", 32'(dis_ptr), 32'd0);
        advance();
        idle();
        sample();
        chk("t2_still_full", 32'(oitf_full), 32'd1);
        chk("t2_ret_rd1", 32'(ret_rd), 32'd1);
        advance();
        idle();
        ret_ena = 1;
        cyc();
        idle();
        sample();
        chk("t2_not_full", 32'(oitf_full), 32'd0);
        chk("t2_ret_rd2", 32'(ret_rd), 32'd2);
        advance();

        // 3: alternating alloc/retire across the wrap
        do_flush();
        for (int i = 0; i < 6; i++) begin
            idle();
            dis_ena = 1; dis_rdwen = 1; dis_rd = RW'(i + 1);
            sample();
            chk("t3_empty_before", 32'(oitf_empty), 32'd1);
            advance();
            idle();
            ret_ena = 1;
            sample();
            chk("t3_ret_ptr", 32'(ret_ptr), 32'(exp_rp[i]));
            chk("t3_busy", {oitf_empty, oitf_full}, 32'd0);
            advance();
        end
        idle();
        sample();
        chk("t3_empty_end", 32'(oitf_empty), 32'd1);
        advance();

        // 4: flush beats simultaneous alloc and retire
        do_flush();
        for (int i = 10; i <= 12; i++) alloc(RW'(i));
        idle();
        flush = 1; dis_ena = 1; ret_ena = 1; dis_rdwen = 1; dis_rd = 5'd11;
        dis_rs1en = 1; dis_rs1 = 5'd10;
        cyc();
        flush = 0; dis_ena = 0; ret_ena = 0;
        sample();
        chk("t4_empty", 32'(oitf_empty), 32'd1);
        chk("t4_full", 32'(oitf_full), 32'd0);
        chk("t4_deps", {oitf_raw_dep, oitf_waw_dep}, 32'd0);
        chk("t4_ptrs", {dis_ptr, ret_ptr}, 32'd0);
        advance();

        // 5: x0 never hazards; WAW on rd=7
        do_flush();
        alloc(5'd0);
        idle();
        dis_rs1en = 1; dis_rs1 = 5'd0;
        sample();
        chk("t5_x0_raw", 32'(oitf_raw_dep), 32'd0);
        advance();
        alloc(5'd7);
        idle();
        dis_rdwen = 1; dis_rd = 5'd7;
        sample();
        chk("t5_waw1", 32'(oitf_waw_dep), 32'd1);
        advance();
        idle();
        dis_rd = 5'd7;
        sample();
        chk("t5_waw0", 32'(oitf_waw_dep), 32'd0);
        advance();

        // 6: simultaneous alloc+retire at count 2 and when full
        do_flush();
        alloc(5'd3);
        alloc(5'd4);
        idle();
        dis_ena = 1; dis_rdwen = 1; dis_rd = 5'd5; ret_ena = 1;
        sample();
        chk("t6_ret_rd3", 32'(ret_rd), 32'd3);
        chk("t6_ret_ptr0", 32'(ret_ptr), 32'd0);
        advance();
        idle();
        sample();
        chk("t6_ret_rd4", 32'(ret_rd), 32'd4);
        chk("t6_ptrs", {dis_ptr, ret_ptr}, {30'd3, 2'd1});
        advance();
        alloc(5'd6);
        alloc(5'd7);
        idle();
        dis_ena = 1; dis_rdwen = 1; dis_rd = 5'd8; ret_ena = 1;
        sample();
        chk("t6_full", 32'(oitf_full), 32'd1);
        advance();
        idle();
        sample();
        chk("t6_after_full", 32'(oitf_full), 32'd0);
        chk("t6_ret_rd5", 32'(ret_rd), 32'd5);
        chk("t6_ptrs2", {dis_ptr, ret_ptr}, {30'd1, 2'd2});
        advance();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset     = ($urandom_range(0, 255) == 0);
            flush     = ($urandom_range(0, 40) == 0);
            dis_ena   = $urandom_range(0, 1) == 1;
            ret_ena   = $urandom_range(0, 2) != 0;
            dis_rdwen = $urandom_range(0, 3) != 0;
            dis_rs1en = $urandom_range(0, 1) == 1;
            dis_rs2en = $urandom_range(0, 1) == 1;
            dis_rd    = RW'($urandom_range(0, 7));
            dis_rs1   = RW'($urandom_range(0, 7));
            dis_rs2   = RW'($urandom_range(0, 7));
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
